// File: rtl/unified_mem_arbiter.sv
// Arbitrates the CPU instruction-fetch and data channels onto one shared single-port SRAM.
// One request is in flight at a time; each read response is held until the CPU takes it.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ready,
  output logic [31:0]           Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ready,
  input  logic [31:0]           Address,
  input  logic                  MemWrite,
  input  logic [31:0]           Write_data,
  input  logic [3:0]            Write_strb,
  input  logic                  MemRead,
  output logic                  Mem_Req_Ready,
  output logic [31:0]           Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ready,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           busy_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic [1:0] {IREAD, DREAD, DWRITE} req_kind_t;

  localparam logic [2:0] LAST_WAIT = 3'(MEM_LATENCY - 1);

  state_t    state;
  req_kind_t kind;
  logic [2:0] wait_cnt;
  logic data_req;
  logic data_hs;
  logic inst_hs;
  logic resp_hs;
  logic unused_addr_bits;

  // Data requests win over a simultaneous fetch; readiness never looks at the response Ready inputs.
  assign data_req       = MemRead | MemWrite;
  assign Mem_Req_Ready  = (state == IDLE);
  assign Inst_Req_Ready = (state == IDLE) & ~MemRead & ~MemWrite;
  assign data_hs        = data_req & Mem_Req_Ready;
  assign inst_hs        = Inst_Req_Valid & Inst_Req_Ready;
  assign resp_hs        = (Inst_Valid & Inst_Ready) | (Read_data_Valid & Read_data_Ready);

  assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0], Address[31:ADDR_WIDTH+2], Address[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      kind            <= IREAD;
      wait_cnt        <= '0;
      Instruction     <= '0;
      Inst_Valid      <= 1'b0;
      Read_data       <= '0;
      Read_data_Valid <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      busy_cnt        <= '0;
    end else begin
      if (state != IDLE)
        busy_cnt <= busy_cnt + 32'd1;

      case (state)
        IDLE: begin
          if (data_hs) begin
            kind     <= MemWrite ? DWRITE : DREAD;
            mem_en   <= 1'b1;
            mem_addr <= Address[ADDR_WIDTH+1:2];
            mem_we   <= MemWrite ? Write_strb : 4'b0000;
            if (MemWrite)
              mem_wdata <= Write_data;
            state <= ACCESS;
          end else if (inst_hs) begin
            kind     <= IREAD;
            mem_en   <= 1'b1;
            mem_addr <= PC[ADDR_WIDTH+1:2];
            mem_we   <= 4'b0000;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          mem_en   <= 1'b0;
          mem_we   <= 4'b0000;
          wait_cnt <= '0;
          state    <= (kind == DWRITE) ? IDLE : WAIT;
        end

        // The SRAM word is on mem_rdata at the final WAIT edge
        WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            if (kind == IREAD) begin
              Instruction <= mem_rdata;
              Inst_Valid  <= 1'b1;
            end else begin
              Read_data       <= mem_rdata;
              Read_data_Valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        RESP: begin
          if (resp_hs) begin
            Inst_Valid      <= 1'b0;
            Read_data_Valid <= 1'b0;
            state           <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: SRAM model, transaction-level reference model,
// per-cycle compare process, directed scenarios with literal expectations, then random traffic.
module tb_unified_mem_arbiter;

  localparam int AW  = 12;
  localparam int LAT = 3;

  logic clk;
  logic rst;
  logic [31:0] PC;
  logic Inst_Req_Valid;
  logic Inst_Req_Ready;
  logic [31:0] Instruction;
  logic Inst_Valid;
  logic Inst_Ready;
  logic [31:0] Address;
  logic MemWrite;
  logic [31:0] Write_data;
  logic [3:0] Write_strb;
  logic MemRead;
  logic Mem_Req_Ready;
  logic [31:0] Read_data;
  logic Read_data_Valid;
  logic Read_data_Ready;
  logic mem_en;
  logic [3:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] busy_cnt;

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy_cnt(busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] preload_word(input int i);
    case (i)
      0:       return 32'h0000_0013;
      1:       return 32'hCAFE_F00D;
      'h41:    return 32'h1122_3344;
      default: return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Response Ready inputs: directed values or random per-cycle values
  bit rand_ready = 0;
  bit dir_inst_ready = 0;
  bit dir_rd_ready = 0;
  bit rnd_inst_ready = 0;
  bit rnd_rd_ready = 0;
  assign Inst_Ready      = rand_ready ? rnd_inst_ready : dir_inst_ready;
  assign Read_data_Ready = rand_ready ? rnd_rd_ready : dir_rd_ready;

  initial forever begin
    @(posedge clk);
    #1;
    rnd_inst_ready = ($urandom_range(0, 2) != 0);
    rnd_rd_ready   = ($urandom_range(0, 2) != 0);
  end

  // SRAM model: byte-writable, read data appears LAT cycles after mem_en
  logic [31:0] sram [4096];
  logic [31:0] rd_pipe [8];
  assign mem_rdata = rd_pipe[LAT-1];

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) sram[i] = preload_word(i);
    for (int i = 0; i < 8; i++) rd_pipe[i] = '0;
    forever begin
      @(posedge clk);
      rd_pipe[0] <= mem_en ? sram[mem_addr] : $urandom();
      for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (mem_en) begin
        w = sram[mem_addr];
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        sram[mem_addr] <= w;
      end
    end
  end

  // Reference model: one transaction at a time, timed by edge arithmetic from its accept edge
  logic [31:0] ref_mem [4096];
  int edge_n = 0;
  bit m_busy = 0;
  bit m_valid = 0;
  bit m_inst = 0;
  bit m_write = 0;
  int m_acc = -10;
  int m_valid_edge = -10;
  logic [3:0] m_strb = '0;
  logic [31:0] m_data = '0;
  logic [AW-1:0] m_word;
  logic exp_inst_valid = 0;
  logic exp_rd_valid = 0;
  logic exp_mem_en = 0;
  logic [3:0] exp_mem_we = '0;
  logic [AW-1:0] exp_mem_addr = '0;
  logic [31:0] exp_instruction = '0;
  logic [31:0] exp_read_data = '0;
  logic [31:0] exp_mem_wdata = '0;
  logic [31:0] exp_busy = '0;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = preload_word(i);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_valid = 0; m_acc = -10; m_valid_edge = -10;
        exp_inst_valid = 0; exp_rd_valid = 0; exp_mem_en = 0; exp_mem_we = '0;
        exp_mem_addr = '0; exp_instruction = '0; exp_read_data = '0;
        exp_mem_wdata = '0; exp_busy = '0;
      end else begin
        edge_n++;
        if (m_busy) exp_busy++;
        if (m_busy) begin
          if (m_write && edge_n == m_acc + 1) begin
            m_busy = 0;
          end else if (m_valid && ((m_inst && Inst_Ready) || (!m_inst && Read_data_Ready))) begin
            m_valid = 0;
            m_busy = 0;
          end else if (!m_write && edge_n == m_valid_edge) begin
            m_valid = 1;
            if (m_inst) exp_instruction = m_data;
            else exp_read_data = m_data;
          end
        end else if (MemRead || MemWrite) begin
          m_busy = 1; m_acc = edge_n; m_inst = 0; m_write = MemWrite; m_strb = Write_strb;
          m_word = Address[AW+1:2];
          exp_mem_addr = m_word;
          if (MemWrite) begin
            exp_mem_wdata = Write_data;
            for (int b = 0; b < 4; b++)
              if (Write_strb[b]) ref_mem[m_word][8*b +: 8] = Write_data[8*b +: 8];
          end else begin
            m_data = ref_mem[m_word];
            m_valid_edge = edge_n + LAT + 1;
          end
        end else if (Inst_Req_Valid) begin
          m_busy = 1; m_acc = edge_n; m_inst = 1; m_write = 0;
          m_word = PC[AW+1:2];
          exp_mem_addr = m_word;
          m_data = ref_mem[m_word];
          m_valid_edge = edge_n + LAT + 1;
        end
        exp_mem_en     = m_busy && (edge_n == m_acc);
        exp_mem_we     = (exp_mem_en && m_write) ? m_strb : 4'b0000;
        exp_inst_valid = m_valid && m_inst;
        exp_rd_valid   = m_valid && !m_inst;
      end
    end
  end

  // Compare every output against the model on each falling edge
  initial forever begin
    @(negedge clk);
    check_output("inst_valid", 32'(Inst_Valid), 32'(exp_inst_valid));
    check_output("instruction", Instruction, exp_instruction);
    check_output("read_data_valid", 32'(Read_data_Valid), 32'(exp_rd_valid));
    check_output("read_data", Read_data, exp_read_data);
    check_output("mem_en", 32'(mem_en), 32'(exp_mem_en));
    check_output("mem_we", 32'(mem_we), 32'(exp_mem_we));
    check_output("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
    check_output("mem_wdata", mem_wdata, exp_mem_wdata);
    check_output("busy_cnt", busy_cnt, exp_busy);
    check_output("mem_req_ready", 32'(Mem_Req_Ready), 32'(!m_busy));
    check_output("inst_req_ready", 32'(Inst_Req_Ready), 32'(!m_busy && !MemRead && !MemWrite));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise a fetch and/or data request and hold each until its handshake edge
  task automatic apply_stimulus(input bit want_inst, input logic [31:0] pc,
                                input bit want_data, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                output int data_acc, output int inst_acc);
    bit inst_pend;
    bit data_pend;
    bit dh;
    bit ih;
    int guard;
    inst_pend = want_inst;
    data_pend = want_data;
    data_acc = -1;
    inst_acc = -1;
    guard = 0;
    while ((inst_pend || data_pend) && guard < 500) begin
      PC = pc;
      Inst_Req_Valid = inst_pend;
      Address = addr;
      MemWrite = data_pend && wr;
      MemRead = data_pend && !wr;
      Write_data = wdata;
      Write_strb = strb;
      #1;
      dh = data_pend && Mem_Req_Ready;
      ih = inst_pend && Inst_Req_Ready;
      @(posedge clk);
      #1;
      if (dh) begin data_pend = 0; data_acc = cyc; end
      if (ih) begin inst_pend = 0; inst_acc = cyc; end
      guard++;
    end
    Inst_Req_Valid = 0;
    MemWrite = 0;
    MemRead = 0;
    if (guard >= 500) check_output("req_accept_timeout", 32'(guard), 32'd0);
  endtask

  task automatic wait_valid(input bit inst, output int waited);
    waited = 0;
    while (!(inst ? Inst_Valid : Read_data_Valid) && waited < 100) begin
      step(1);
      waited++;
    end
    if (waited >= 100) check_output(inst ? "inst_valid_timeout" : "rd_valid_timeout", 32'(waited), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int da;
    int ia;
    int w;
    logic [31:0] b0;
    logic [31:0] addr;
    int kind;

    rst = 1'b1;
    PC = '0; Inst_Req_Valid = 0; Address = '0; MemWrite = 0; MemRead = 0;
    Write_data = '0; Write_strb = '0;
    step(3);

    // Reset state
    check_output("rst_inst_valid", 32'(Inst_Valid), 32'd0);
    check_output("rst_rd_valid", 32'(Read_data_Valid), 32'd0);
    check_output("rst_mem_en", 32'(mem_en), 32'd0);
    check_output("rst_busy_cnt", busy_cnt, 32'd0);
    check_output("rst_mem_req_ready", 32'(Mem_Req_Ready), 32'd1);
    rst = 1'b0;
    step(2);
    check_output("idle_busy_cnt", busy_cnt, 32'd0);

    // Fetch of word 0: valid LAT+1 = 4 edges after accept
    dir_inst_ready = 1;
    apply_stimulus(1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, da, ia);
    wait_valid(1, w);
    check_output("t1_latency", 32'(cyc - ia), 32'd4);
    check_output("t1_instruction", Instruction, 32'h0000_0013);
    step(1);
    check_output("t1_consumed", 32'(Inst_Valid), 32'd0);

    // Byte-lane write then read back
    apply_stimulus(0, 32'h0, 1, 1, 32'h104, 32'hAABB_CCDD, 4'b0100, da, ia);
    dir_rd_ready = 1;
    apply_stimulus(0, 32'h0, 1, 0, 32'h104, 32'h0, 4'h0, da, ia);
    wait_valid(0, w);
    check_output("t2_read_data", Read_data, 32'h11BB_3344);
    step(1);

    // Simultaneous data read and fetch: data first, fetch LAT+3 edges later
    PC = 32'h0; Inst_Req_Valid = 1; MemRead = 1; Address = 32'h8;
    #1;
    check_output("t3_mem_req_ready", 32'(Mem_Req_Ready), 32'd1);
    check_output("t3_inst_req_ready", 32'(Inst_Req_Ready), 32'd0);
    apply_stimulus(1, 32'h0, 1, 0, 32'h8, 32'h0, 4'h0, da, ia);
    check_output("t3_order", 32'(ia - da), 32'd6);
    wait_valid(1, w);
    step(1);

    // Response held 10 cycles with Read_data_Ready low
    dir_rd_ready = 0;
    apply_stimulus(0, 32'h0, 1, 0, 32'h104, 32'h0, 4'h0, da, ia);
    b0 = busy_cnt;
    wait_valid(0, w);
    for (int i = 0; i < 10; i++) begin
      check_output("t4_hold_valid", 32'(Read_data_Valid), 32'd1);
      check_output("t4_hold_data", Read_data, 32'h11BB_3344);
      check_output("t4_no_accept", 32'(Mem_Req_Ready), 32'd0);
      step(1);
    end
    dir_rd_ready = 1;
    step(1);
    check_output("t4_busy_delta", busy_cnt - b0, 32'd15);
    check_output("t4_released", 32'(Read_data_Valid), 32'd0);

    // Aliased address 0x4004 reads word 1
    apply_stimulus(0, 32'h0, 1, 0, 32'h4004, 32'h0, 4'h0, da, ia);
    wait_valid(0, w);
    check_output("t5_alias", Read_data, 32'hCAFE_F00D);
    step(1);

    // Reset during WAIT of a fetch
    apply_stimulus(1, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0, da, ia);
    step(1);
    rst = 1'b1;
    #1;
    check_output("t6_instruction", Instruction, 32'd0);
    check_output("t6_inst_valid", 32'(Inst_Valid), 32'd0);
    check_output("t6_read_data", Read_data, 32'd0);
    check_output("t6_rd_valid", 32'(Read_data_Valid), 32'd0);
    check_output("t6_mem_en", 32'(mem_en), 32'd0);
    check_output("t6_mem_we", 32'(mem_we), 32'd0);
    check_output("t6_mem_addr", 32'(mem_addr), 32'd0);
    check_output("t6_mem_wdata", mem_wdata, 32'd0);
    check_output("t6_busy_cnt", busy_cnt, 32'd0);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_output("t6_no_stale_resp", 32'(Inst_Valid), 32'd0);
    end
    apply_stimulus(1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, da, ia);
    wait_valid(1, w);
    check_output("t6_refetch", Instruction, 32'h0000_0013);
    step(1);

    // Random traffic against the model
    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 4);
      addr = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      case (kind)
        0: apply_stimulus(1, addr, 0, 0, 32'h0, 32'h0, 4'h0, da, ia);
        1: apply_stimulus(0, 32'h0, 1, 0, addr, 32'h0, 4'h0, da, ia);
        2: apply_stimulus(0, 32'h0, 1, 1, addr, $urandom(), 4'($urandom_range(0, 15)), da, ia);
        3: apply_stimulus(1, addr ^ 32'h10, 1, 0, addr, 32'h0, 4'h0, da, ia);
        default: apply_stimulus(1, addr ^ 32'h20, 1, 1, addr, $urandom(), 4'($urandom_range(0, 15)), da, ia);
      endcase
    end
    w = 0;
    while (m_busy && w < 200) begin
      step(1);
      w++;
    end
    if (w >= 200) check_output("drain_timeout", 32'(w), 32'd0);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
